mux_out_skid: RTL

Registered valid/ready output stage that sits directly downstream of the 8-bit 2:1 select mux (`day1`) and consumes its `y_o`. It captures the mux result under a valid/ready handshake, decouples downstream backpressure from the combinational mux path with a 2-entry skid buffer, and sustains one transfer per cycle with one cycle of latency.

---
 rtl/mux_skid_pkg.sv | 14 +
 rtl/mux_skid_xfer_cnt.sv | 20 ++
 rtl/mux_out_skid.sv | 84 ++++++++
 3 files changed

// File: rtl/mux_skid_pkg.sv
// Shared types and constants for the mux output skid stage.
// The transfer counter is enabled with MUX_SKID_CNT_EN.
package mux_skid_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int XFER_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mux_skid_xfer_cnt.sv
// Free-running output handshake counter, wraps at 2^XFER_CNT_W.
// Only instantiated when MUX_SKID_CNT_EN is defined.
module mux_skid_xfer_cnt
    import mux_skid_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc_i,
    output logic [XFER_CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_o <= '0;
        end else if (inc_i) begin
            cnt_o <= cnt_o + XFER_CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_out_skid.sv
// Registered valid/ready output stage with a 2-entry skid buffer.
// Optional xfer_cnt_o port/counter under MUX_SKID_CNT_EN.
module mux_out_skid
    import mux_skid_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
`ifdef MUX_SKID_CNT_EN
    ,
    output logic [XFER_CNT_W-1:0] xfer_cnt_o
`endif
);

    skid_state_t       state;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    // in_ready_o/out_valid_o are flops updated alongside the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            skid_q      <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_data_o  <= in_data_i;
                        out_valid_o <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        out_data_o <= in_data_i;
                    end else if (in_fire) begin
                        skid_q     <= in_data_i;
                        in_ready_o <= 1'b0;
                        state      <= FULL;
                    end else if (out_fire) begin
                        out_valid_o <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_data_o <= skid_q;
                        in_ready_o <= 1'b1;
                        state      <= BUSY;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_SKID_CNT_EN
    mux_skid_xfer_cnt u_xfer_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (out_fire),
        .cnt_o   (xfer_cnt_o)
    );
`endif

endmodule
